// File: rtl/mvm_arb_sched.sv
// Two-requester round-robin sequencer for a shared MVM engine; optional busy watchdog via `define MVM_ARB_TIMEOUT_EN.
// Latency: request sampled in IDLE -> grant and o_mvm_start 1 cycle later; o_done 1 cycle after the engine's busy falling edge.
// Backpressure: requests are level-held until o_done; at most one job in flight, with at least one IDLE cycle between jobs.
module mvm_arb_sched #(
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 1024
) (
   input  logic             i_clk_mvmArb,
   input  logic             i_rst_mvmArb,
   input  logic [1:0]       i_req,
   output logic [1:0]       o_gnt,
   output logic [1:0]       o_done,
   output logic             o_sel,
   output logic             o_mvm_start,
   input  logic             i_mvm_isAcc,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_cycles,
   output logic             o_timeout
);

   typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic             ptr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             winner;
   logic             wd_hit;

   // The watchdog limit must be representable in the job counter.
   if (TIMEOUT < 1 || longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_bad_timeout
      $error("mvm_arb_sched: TIMEOUT out of range for CNT_W");
   end

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   assign winner  = (i_req == 2'b11) ? ptr : i_req[1];

`ifdef MVM_ARB_TIMEOUT_EN
   assign wd_hit = (cnt_inc == CNT_W'(TIMEOUT));
`else
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge i_clk_mvmArb) begin
      if (i_rst_mvmArb) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         cnt         <= '0;
         o_gnt       <= 2'b00;
         o_done      <= 2'b00;
         o_sel       <= 1'b0;
         o_mvm_start <= 1'b0;
         o_busy      <= 1'b0;
         o_cycles    <= '0;
         o_timeout   <= 1'b0;
      end else begin
         o_mvm_start <= 1'b0;
         o_done      <= 2'b00;
         o_timeout   <= 1'b0;
         case (state)
            IDLE: begin
               if (|i_req) begin
                  state       <= START;
                  o_gnt       <= winner ? 2'b10 : 2'b01;
                  o_sel       <= winner;
                  ptr         <= ~winner;
                  cnt         <= '0;
                  o_mvm_start <= 1'b1;
                  o_busy      <= 1'b1;
               end
            end
            START: begin
               state <= WAIT_HI;
               cnt   <= cnt_inc;
            end
            WAIT_HI, WAIT_LO: begin
               cnt <= cnt_inc;
               // Natural completion wins over a watchdog hit in the same cycle.
               if (state == WAIT_LO && !i_mvm_isAcc) begin
                  state    <= DONE;
                  o_done   <= o_gnt;
                  o_cycles <= cnt_inc;
               end else if (wd_hit) begin
                  state     <= DONE;
                  o_done    <= o_gnt;
                  o_timeout <= 1'b1;
                  o_cycles  <= cnt_inc;
               end else if (state == WAIT_HI && i_mvm_isAcc) begin
                  state <= WAIT_LO;
               end
            end
            DONE: begin
               state  <= IDLE;
               o_gnt  <= 2'b00;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               o_gnt  <= 2'b00;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_arb_sched.sv
// Bench for mvm_arb_sched: directed scenarios then randomized traffic, all checked
// cycle by cycle against a job-level reference model built from cycle timestamps.
module tb_mvm_arb_sched;
   localparam int CNT_W   = 5;
   localparam int TIMEOUT = 16;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req;
   logic             is_acc;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             sel;
   logic             mvm_start;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] cycles;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // engine behaviour: busy for eng_l cycles starting eng_d cycles after START
   int eng_t0 = -1000000;
   int eng_d  = 1;
   int eng_l  = 2;
   bit auto_eng = 1'b0;
   bit auto_req = 1'b0;
   bit auto_rst = 1'b0;

   // reference model: job owner, START timestamp, DONE timestamp
   bit m_act = 1'b0;
   bit m_own = 1'b0;
   bit m_ptr = 1'b0;
   bit m_hi  = 1'b0;
   bit m_tmo = 1'b0;
   int m_t0  = 0;
   int m_done_at = -1;
   int m_cycles  = 0;

   always #5 clk = ~clk;

   mvm_arb_sched #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (
      .i_clk_mvmArb (clk),
      .i_rst_mvmArb (rst),
      .i_req        (req),
      .o_gnt        (gnt),
      .o_done       (done),
      .o_sel        (sel),
      .o_mvm_start  (mvm_start),
      .i_mvm_isAcc  (is_acc),
      .o_busy       (busy),
      .o_cycles     (cycles),
      .o_timeout    (timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Advance the model from the inputs seen during cycle 'cyc' to cycle cyc+1.
   function automatic void model_step(input bit r, input bit [1:0] rq, input bit a);
      int nxt;
      int el;
      nxt = cyc + 1;
      if (r) begin
         m_act = 1'b0; m_own = 1'b0; m_ptr = 1'b0; m_tmo = 1'b0;
         m_cycles = 0; m_done_at = -1;
         return;
      end
      if (!m_act) begin
         if (rq != 2'b00) begin
            m_own = (rq == 2'b11) ? m_ptr : rq[1];
            m_ptr = !m_own;
            m_act = 1'b1; m_t0 = nxt; m_hi = 1'b0; m_tmo = 1'b0; m_done_at = -1;
         end
      end else if (m_done_at == cyc) begin
         m_act = 1'b0;
      end else if (cyc > m_t0 && m_done_at < 0) begin
         el = nxt - m_t0;
         if (m_hi && !a) begin
            m_done_at = nxt;
            m_cycles  = (el > CMAX) ? CMAX : el;
         end
`ifdef MVM_ARB_TIMEOUT_EN
         else if (el == TIMEOUT) begin
            m_done_at = nxt; m_cycles = TIMEOUT; m_tmo = 1'b1;
         end
`endif
         else if (a) begin
            m_hi = 1'b1;
         end
      end
   endfunction

   task automatic compare_all();
      logic [1:0] e_gnt;
      logic       e_fin;
      e_gnt = m_act ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      e_fin = m_act && (m_done_at == cyc);
      check("gnt",     32'(gnt),       32'(e_gnt));
      check("sel",     32'(sel),       32'(m_own));
      check("start",   32'(mvm_start), 32'(m_act && cyc == m_t0));
      check("done",    32'(done),      32'(e_fin ? e_gnt : 2'b00));
      check("busy",    32'(busy),      32'(m_act));
      check("cycles",  32'(cycles),    32'(m_cycles));
      check("timeout", 32'(timeout),   32'(e_fin && m_tmo));
   endtask

   task automatic step();
      @(negedge clk);
      is_acc = (cyc >= eng_t0 + eng_d) && (cyc < eng_t0 + eng_d + eng_l);
      if (auto_rst) rst = ($urandom_range(299, 0) == 0);
      if (auto_req) begin
         for (int i = 0; i < 2; i++) begin
            if (!req[i])                        req[i] = ($urandom_range(2, 0) == 0);
            else if (done[i])                   req[i] = ($urandom_range(1, 0) == 0);
            else if ($urandom_range(39, 0) == 0) req[i] = 1'b0;
         end
      end
      @(posedge clk);
      model_step(rst, req, is_acc);
      cyc++;
      #1;
      compare_all();
      if (mvm_start === 1'b1) begin
         eng_t0 = cyc;
         if (auto_eng) begin
            eng_d = $urandom_range(3, 0);
            eng_l = $urandom_range(40, (eng_d == 0) ? 2 : 1);
         end
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         seen = (done !== 2'b00);
      end
      check({tag, "_seen"}, 32'(seen), 32'(1));
   endtask

   initial begin
      int n_done;
      rst = 1'b1; req = 2'b00; is_acc = 1'b0;
      repeat (3) step();
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_cycles", 32'(cycles), 32'(0));
      rst = 1'b0;

      // single request, engine busy 5 cycles from START+1
      eng_d = 1; eng_l = 5; req = 2'b01;
      step();
      check("s1_gnt", 32'(gnt), 32'(1));
      check("s1_start", 32'(mvm_start), 32'(1));
      wait_done("s1", 40);
      check("s1_done", 32'(done), 32'(1));
      check("s1_cycles", 32'(cycles), 32'(7));
      req = 2'b00;
      repeat (2) step();

      // engine rises with START, falls one cycle later
      eng_d = 0; eng_l = 2; req = 2'b10;
      step();
      wait_done("s6", 40);
      check("s6_done", 32'(done), 32'(2));
      check("s6_cycles", 32'(cycles), 32'(3));
      req = 2'b00;
      repeat (2) step();

      // both requesting from reset: strict alternation
      rst = 1'b1; req = 2'b11; eng_d = 1; eng_l = 2;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_done("s2", 40);
         check("s2_order", 32'(done), 32'((k % 2 == 0) ? 1 : 2));
      end
      req = 2'b00;
      repeat (2) step();

      // requester drops mid-job
      req = 2'b01; eng_d = 1; eng_l = 6;
      repeat (4) step();
      req = 2'b00;
      wait_done("s3", 40);
      check("s3_done", 32'(done), 32'(1));
      for (int k = 0; k < 5; k++) begin
         step();
         check("s3_idle", 32'(busy), 32'(0));
      end

      // reset while waiting for the engine; pointer returns to requester 0
      req = 2'b11; eng_d = 1; eng_l = 10;
      repeat (4) step();
      rst = 1'b1;
      step();
      check("s4_gnt", 32'(gnt), 32'(0));
      check("s4_busy", 32'(busy), 32'(0));
      check("s4_done", 32'(done), 32'(0));
      rst = 1'b0;
      step();
      check("s4_regnt", 32'(gnt), 32'(1));
      wait_done("s4", 40);
      req = 2'b00;
      repeat (2) step();

      // engine stuck busy
      req = 2'b01; eng_d = 1; eng_l = 1 << 30;
      step();
      n_done = 0;
      repeat (1000) begin
         step();
         if (done !== 2'b00) n_done++;
      end
`ifndef MVM_ARB_TIMEOUT_EN
      check("s5_no_done", 32'(n_done), 32'(0));
      check("s5_busy", 32'(busy), 32'(1));
`endif
      rst = 1'b1; req = 2'b00; eng_l = 2; eng_t0 = -1000000;
      step();
      rst = 1'b0;
      step();

      // randomized traffic
      auto_eng = 1'b1; auto_req = 1'b1; auto_rst = 1'b1;
      repeat (4000) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
